fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the pipelined MIPS core. It tracks the destination tags of in-flight instructions in an internal shadow pipeline, so the datapath only presents the decode-stage instruction. Each cycle it produces a forwarding select for every source operand of the instruction in EX and a load-use stall request for ID. It generalises the two-operand, two-producer-stage forwarding logic to NUM_SRC operands and FWD_DEPTH producer stages, and adds hazard detection, flush and freeze handling.

## Interface
- REG_AW, 5, register address width
- NUM_SRC, 2, source operands per instruction (1..4)
- FWD_DEPTH, 2, producer stages after EX that can forward (2..4; stage 1 = EX/MEM, stage 2 = MEM/WB, ...)
- SEL_W, $clog2(FWD_DEPTH+1), derived width of one forwarding select

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_src  in  NUM_SRC*REG_AW  ID source register addresses, operand i at bits [i*REG_AW +: REG_AW]
- id_rd  in  REG_AW  ID destination register
- id_regwrite  in  1  ID instruction writes the register file
- id_memread  in  1  ID instruction is a load
- flush  in  1  squash ID and EX (taken branch/jump)
- freeze  in  1  external stall; hold all state
- fwd_sel  out  NUM_SRC*SEL_W  per EX operand: 0 = register file, k = forward from producer stage k
- ld_stall  out  1  hold PC and IF/ID, insert bubble into EX
- stall_cnt  out  32  load-use stall cycles (see Configuration)

## Operation
- Tag = {valid, rd, regwrite, is_load, src[NUM_SRC]}. State: one EX tag plus FWD_DEPTH producer tags P1..P_FWD_DEPTH. Producer tags keep only valid/rd/regwrite/is_load.
- Producer k is a match for EX operand i when: valid, regwrite, rd != 0, and rd == EX src[i].
- fwd_sel[i] = smallest matching k (youngest producer wins); 0 when there is no match.
- A load in P1 is never a match; its data first exists at P2. This case is unreachable while ld_stall works correctly, and the bench asserts that it never occurs.
- ld_stall = id_valid & EX.valid & EX.is_load & EX.regwrite & EX.rd != 0 & (EX.rd equals any id_src[i]) & !flush.
- Update priority each edge: reset > freeze > flush > ld_stall > advance.
  - reset: every tag.valid <= 0.
  - freeze: all tags hold.
  - flush: P1 <= EX; P(k) <= P(k-1); EX <= bubble (valid = 0).
  - ld_stall: same shift as flush (the load moves to P1, EX becomes a bubble, the ID instruction is held outside).
  - advance: P shifts as above; EX <= ID fields with valid = id_valid.
- The oldest producer tag drops off the end of the chain. Register-file write-before-read covers the following cycle.

## Timing
- fwd_sel is combinational from registered tags. It is valid in the same cycle the instruction occupies EX; there is no added latency.
- ld_stall is combinational from the ID inputs and the EX tag, in the same cycle. It asserts for exactly one cycle per load-use pair. After the stall, the consumer enters EX with the load in P2, so fwd_sel = 2.
- Reset values: fwd_sel = 0, ld_stall = 0, stall_cnt = 0, all tags invalid. The first cycle after reset deasserts forwards nothing.
- Reset asserted mid-operation discards all in-flight tags on that edge.
- While freeze is high, outputs hold their values (inputs are held by the pipeline), and stall_cnt does not count.
- flush and ld_stall conditions in the same cycle: flush wins and ld_stall reads 0.
- Operand reading $0: fwd_sel = 0 always.
- Two operands naming the same register: both receive the same select.

## Configuration
- FWD_STALL_CNT_EN defined: stall_cnt increments on every edge where ld_stall & !freeze & !reset, and saturates at 32'hFFFF_FFFF.
- FWD_STALL_CNT_EN undefined: the counter logic is absent, and stall_cnt is tied to 0.

## Structure
- Package fwd_pkg holds:
  - fwd_tag_t (valid, rd, regwrite, is_load)
  - REG_ZERO constant
  - FWD_SEL_RF = 0
  - sel_width() function
- Sub-module fwd_match: one EX source address plus the producer tag vector in, priority-encoded select out. It is instantiated NUM_SRC times.
- The top level contains the tag shift register, the hazard compare and the optional counter.

## Test plan
- add $3 in EX, next cycle sub using $3 enters EX -> fwd_sel[0] = 1. One cycle later an or using $3 enters EX -> fwd_sel = 2.
- lw $5 in EX, ID uses $5 -> ld_stall = 1 for one cycle. The consumer then enters EX with fwd_sel = 2, and stall_cnt = 1 (with FWD_STALL_CNT_EN).
- Writers of $7 in both P1 and P2, EX reads $7 in both operands -> fwd_sel = {1,1} (youngest wins).
- Writer with rd = $0 and regwrite = 1 in P1, EX reads $0 -> fwd_sel = 0. A load to $0 in EX -> ld_stall = 0.
- Load-use condition with flush = 1 -> ld_stall = 0. The next cycle EX is a bubble and the load is in P1.
- freeze held 3 cycles with a hazard pending -> tags and outputs stable and stall_cnt unchanged. Reset pulse mid-sequence -> all fwd_sel = 0 on the next cycle.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
// Tag rd fields are stored at TAG_RD_W bits; REG_AW must not exceed it.
package fwd_pkg;

  localparam int TAG_RD_W = 8;
  localparam logic [TAG_RD_W-1:0] REG_ZERO = '0;
  localparam int FWD_SEL_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [TAG_RD_W-1:0] rd;
    logic                regwrite;
    logic                is_load;
  } fwd_tag_t;

  function automatic int sel_width(input int fwdDepth);
    return $clog2(fwdDepth + 1);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Priority-encodes the youngest producer stage that can forward to one EX source operand.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = sel_width(FWD_DEPTH)
) (
  input  logic [REG_AW-1:0]             exSrc,
  input  fwd_tag_t [FWD_DEPTH-1:0]      prodTags,
  output logic [SEL_W-1:0]              sel
);

  logic [TAG_RD_W-1:0] srcExt;
  assign srcExt = TAG_RD_W'(exSrc);

  // Scan oldest to youngest so the youngest match is written last.
  // A load sitting in P1 has no data yet, so it never forwards from there.
  always_comb begin
    sel = SEL_W'(FWD_SEL_RF);
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (prodTags[k].valid && prodTags[k].regwrite &&
          (prodTags[k].rd != REG_ZERO) && (prodTags[k].rd == srcExt) &&
          !((k == 0) && prodTags[k].is_load)) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Shadow-pipeline forwarding selects and load-use stall for the MIPS core.
// Optional stall counter enabled by defining FWD_STALL_CNT_EN.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int REG_AW    = 5,
  parameter int NUM_SRC   = 2,
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = sel_width(FWD_DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_memread,
  input  logic                      flush,
  input  logic                      freeze,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      ld_stall,
  output logic [31:0]               stall_cnt
);

  fwd_tag_t                  exTag;
  logic [NUM_SRC*REG_AW-1:0] exSrc;
  fwd_tag_t [FWD_DEPTH-1:0]  prodTags;
  logic                      srcHit;

  always_comb begin
    srcHit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (TAG_RD_W'(id_src[i*REG_AW +: REG_AW]) == exTag.rd) srcHit = 1'b1;
    end
  end

  assign ld_stall = id_valid && exTag.valid && exTag.is_load && exTag.regwrite &&
                    (exTag.rd != REG_ZERO) && srcHit && !flush;

  // Bubbles carry $0 sources so an empty EX slot never selects a forward.
  always_ff @(posedge clk) begin
    if (reset) begin
      exTag    <= '0;
      exSrc    <= '0;
      prodTags <= '0;
    end else if (!freeze) begin
      prodTags[0] <= exTag;
      for (int k = FWD_DEPTH - 1; k > 0; k--) prodTags[k] <= prodTags[k-1];
      if (flush || ld_stall) begin
        exTag <= '0;
        exSrc <= '0;
      end else begin
        exTag <= '{valid: id_valid, rd: TAG_RD_W'(id_rd),
                   regwrite: id_regwrite, is_load: id_memread};
        exSrc <= id_src;
      end
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : gMatch
    fwd_match #(
      .REG_AW    (REG_AW),
      .FWD_DEPTH (FWD_DEPTH),
      .SEL_W     (SEL_W)
    ) uMatch (
      .exSrc    (exSrc[i*REG_AW +: REG_AW]),
      .prodTags (prodTags),
      .sel      (fwd_sel[i*SEL_W +: SEL_W])
    );
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stallCntQ;
  always_ff @(posedge clk) begin
    if (reset) begin
      stallCntQ <= '0;
    end else if (ld_stall && !freeze && (stallCntQ != 32'hFFFF_FFFF)) begin
      stallCntQ <= stallCntQ + 32'd1;
    end
  end
  assign stall_cnt = stallCntQ;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit with a reference shadow-pipeline model.
module tb_fwd_hazard_unit;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int FD = 2;
  localparam int SW = $clog2(FD + 1);
  localparam int EXP_W = NS*SW + 1 + 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             id_valid;
  logic [NS*AW-1:0] id_src;
  logic [AW-1:0]    id_rd;
  logic             id_regwrite;
  logic             id_memread;
  logic             flush;
  logic             freeze;
  logic [NS*SW-1:0] fwd_sel;
  logic             ld_stall;
  logic [31:0]      stall_cnt;

  fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NS), .FWD_DEPTH(FD), .SEL_W(SW)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_src(id_src), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush), .freeze(freeze),
    .fwd_sel(fwd_sel), .ld_stall(ld_stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  logic [EXP_W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int stepNo = 0;

  // Reference model state: index 1..FD are producer stages P1..P_FD.
  logic        pv[1:FD], prw[1:FD], pld[1:FD];
  int          prd[1:FD];
  logic        ev, erw, eld;
  int          erd;
  int          esrc[NS];
  logic [31:0] mCnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @step %0d: got %0h expected %0h", tag, stepNo, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 1; k <= FD; k++) begin
      pv[k] = 0; prw[k] = 0; pld[k] = 0; prd[k] = 0;
    end
    ev = 0; erw = 0; eld = 0; erd = 0;
    for (int i = 0; i < NS; i++) esrc[i] = 0;
    mCnt = '0;
  endtask

  task automatic step(input logic v, input int s0, input int s1, input int rd,
                      input logic rw, input logic ld, input logic fl, input logic fz,
                      input logic rs);
    logic [NS*SW-1:0] expSel;
    logic             expStall, hit, p1LoadHit;
    logic [EXP_W-1:0] ent;
    int               src[NS];
    src[0] = s0; src[1] = s1;
    id_valid = v; id_src = {AW'(s1), AW'(s0)}; id_rd = AW'(rd);
    id_regwrite = rw; id_memread = ld; flush = fl; freeze = fz; reset = rs;

    expSel = '0;
    p1LoadHit = 1'b0;
    for (int i = 0; i < NS; i++) begin
      int sel;
      sel = 0;
      for (int k = 1; k <= FD; k++) begin
        if (sel == 0 && pv[k] && prw[k] && prd[k] != 0 && prd[k] == esrc[i] &&
            !(k == 1 && pld[k])) sel = k;
      end
      expSel[i*SW +: SW] = SW'(sel);
      if (ev && pv[1] && pld[1] && prw[1] && prd[1] != 0 && prd[1] == esrc[i])
        p1LoadHit = 1'b1;
    end
    hit = 1'b0;
    for (int i = 0; i < NS; i++) if (src[i] == erd) hit = 1'b1;
    expStall = v && ev && eld && erw && (erd != 0) && hit && !fl;
    exp_q.push_back({expSel, expStall, mCnt});

    @(negedge clk);
    ent = exp_q.pop_front();
    check("fwd_sel", 64'(fwd_sel), 64'(ent[EXP_W-1 -: NS*SW]));
    check("ld_stall", 64'(ld_stall), 64'(ent[32]));
    check("stall_cnt", 64'(stall_cnt), 64'(ent[31:0]));
    check("p1_load_use", 64'(p1LoadHit), 64'd0);

    @(posedge clk);
    if (rs) begin
      model_reset();
    end else if (!fz) begin
`ifdef FWD_STALL_CNT_EN
      if (expStall && mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 1;
`endif
      for (int k = FD; k > 1; k--) begin
        pv[k] = pv[k-1]; prw[k] = prw[k-1]; pld[k] = pld[k-1]; prd[k] = prd[k-1];
      end
      pv[1] = ev; prw[1] = erw; pld[1] = eld; prd[1] = erd;
      if (fl || expStall) begin
        ev = 0; erw = 0; eld = 0; erd = 0;
        for (int i = 0; i < NS; i++) esrc[i] = 0;
      end else begin
        ev = v; erw = rw; eld = ld; erd = rd;
        for (int i = 0; i < NS; i++) esrc[i] = src[i];
      end
    end
    stepNo++;
    #1;
  endtask

  initial begin
    reset = 1; id_valid = 0; id_src = '0; id_rd = '0;
    id_regwrite = 0; id_memread = 0; flush = 0; freeze = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    //   v  s0 s1 rd rw ld fl fz rs
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);   // reset state
    step(1, 1, 2, 3, 1, 0, 0, 0, 0);   // add $3
    step(1, 3, 1, 4, 1, 0, 0, 0, 0);   // sub $4,$3
    step(1, 3, 5, 6, 1, 0, 0, 0, 0);   // or $6,$3 ; EX=sub sel0=1
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);   // EX=or sel0=2
    step(1, 2, 0, 5, 1, 1, 0, 0, 0);   // lw $5
    step(1, 5, 5, 8, 1, 0, 0, 0, 0);   // load-use stall
    step(1, 5, 5, 8, 1, 0, 0, 0, 0);   // held consumer, EX bubble
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);   // consumer in EX, sel={2,2}
    step(1, 1, 1, 7, 1, 0, 0, 0, 0);   // write $7
    step(1, 2, 2, 7, 1, 0, 0, 0, 0);   // write $7 again
    step(1, 7, 7, 9, 1, 0, 0, 0, 0);   // read $7,$7
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);   // youngest wins {1,1}
    step(1, 1, 1, 0, 1, 0, 0, 0, 0);   // write $0
    step(1, 0, 0, 0, 1, 1, 0, 0, 0);   // lw $0
    step(1, 0, 0, 2, 1, 0, 0, 0, 0);   // read $0 behind lw $0: no stall
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);   // $0 never forwards
    step(1, 1, 0, 10, 1, 1, 0, 0, 0);  // lw $10
    step(1, 10, 0, 11, 1, 0, 1, 0, 0); // hazard under flush
    step(1, 10, 1, 12, 1, 0, 0, 0, 0); // EX bubble, lw in P1
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);   // reader sees lw in P2
    step(1, 2, 0, 11, 1, 1, 0, 0, 0);  // lw $11
    for (int n = 0; n < 3; n++)
      step(1, 11, 11, 13, 1, 0, 0, 1, 0); // frozen with hazard pending
    step(1, 11, 11, 13, 1, 0, 0, 0, 0);
    step(1, 11, 11, 13, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 12, 1, 0, 0, 0, 0);  // add $12
    step(1, 12, 0, 14, 1, 0, 0, 0, 0);
    step(1, 12, 12, 15, 1, 0, 0, 0, 1); // reset edge mid-sequence
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);    // everything cleared
    for (int n = 0; n < 120; n++) begin
      logic v, rw;
      v  = (32'($urandom_range(0, 3)) != 0);
      rw = 1'($urandom_range(0, 1));
      step(v, v ? 32'($urandom_range(0, 3)) : 0, v ? 32'($urandom_range(0, 3)) : 0,
           32'($urandom_range(0, 3)), rw, rw && ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 39) == 0));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
